// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_driver
// Purpose  : Time-multiplexed driver for a common-pin 7-segment display.
//            Captures hex data into shadow registers on a load strobe and
//            scans the digits one at a time, with per-digit enable, decimal
//            points and optional leading-zero suppression.
// Ports    : clk        - system clock, rising edge
//            rst_n      - asynchronous active-low reset
//            value      - 4*NUM_DIGITS hex nibbles, nibble i drives digit i
//            dp_in      - decimal point request per digit
//            digit_en   - per-digit enable (0 = dark)
//            blank_lz   - 1 = suppress leading zeros
//            load       - strobe capturing value/dp_in into the shadow
//            seg        - segments a..g on seg[6]..seg[0]
//            dp         - decimal point segment
//            an         - digit select, one-hot when a digit is lit
//            scan_tick  - one-cycle pulse at each digit advance
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    blank_lz,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    scan_tick
);

  localparam int c_cw = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int c_iw = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [c_cw-1:0] c_cnt_max = c_cw'(REFRESH_DIV - 1);
  localparam logic [c_iw-1:0] c_idx_max = c_iw'(NUM_DIGITS - 1);
  // XOR mask turning logical (active-high) levels into pin levels
  localparam logic c_pol = (ACTIVE_LOW != 0);

  logic [c_cw-1:0]         r_cnt;
  logic [c_iw-1:0]         r_idx;
  logic                    r_tick;
  logic [4*NUM_DIGITS-1:0] r_shadow_val;
  logic [NUM_DIGITS-1:0]   r_shadow_dp;
  logic [6:0]              r_seg;
  logic                    r_dp;
  logic [NUM_DIGITS-1:0]   r_an;

  logic                    w_tc;
  logic [NUM_DIGITS:1]     w_upper_zero;
  logic [NUM_DIGITS-1:0]   w_blank;
  logic [3:0]              w_nib;
  logic                    w_sel_dp;
  logic                    w_sel_en;
  logic                    w_sel_blank;
  logic                    w_lit;
  logic [6:0]              w_seg;
  logic                    w_dp;
  logic [NUM_DIGITS-1:0]   w_an;

  // Logical segment pattern, bit 6 = a ... bit 0 = g
  function automatic logic [6:0] f_decode(input logic [3:0] nib);
    case (nib)
      4'h0: f_decode = 7'h7E;
      4'h1: f_decode = 7'h30;
      4'h2: f_decode = 7'h6D;
      4'h3: f_decode = 7'h79;
      4'h4: f_decode = 7'h33;
      4'h5: f_decode = 7'h5B;
      4'h6: f_decode = 7'h5F;
      4'h7: f_decode = 7'h70;
      4'h8: f_decode = 7'h7F;
      4'h9: f_decode = 7'h7B;
      4'hA: f_decode = 7'h77;
      4'hB: f_decode = 7'h1F;
      4'hC: f_decode = 7'h4E;
      4'hD: f_decode = 7'h3D;
      4'hE: f_decode = 7'h4F;
      default: f_decode = 7'h47;
    endcase
  endfunction

  assign w_tc = (r_cnt == c_cnt_max);

  // w_upper_zero[i]: shadow nibbles NUM_DIGITS-1 down to i are all zero.
  // Digit 0 is never blanked, so the chain stops at digit 1.
  assign w_upper_zero[NUM_DIGITS] = 1'b1;
  assign w_blank[0]               = 1'b0;

  generate
    for (genvar i = 1; i < NUM_DIGITS; i++) begin : g_lz
      assign w_upper_zero[i] = (r_shadow_val[4*i +: 4] == 4'h0) && w_upper_zero[i+1];
      assign w_blank[i]      = blank_lz && w_upper_zero[i];
    end
  endgenerate

  // Select the currently scanned digit and build its logical outputs
  always_comb begin
    w_nib       = 4'h0;
    w_sel_dp    = 1'b0;
    w_sel_en    = 1'b0;
    w_sel_blank = 1'b0;
    w_an        = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == c_iw'(i)) begin
        w_nib       = r_shadow_val[4*i +: 4];
        w_sel_dp    = r_shadow_dp[i];
        w_sel_en    = digit_en[i];
        w_sel_blank = w_blank[i];
        w_an[i]     = 1'b1;
      end
    end
    w_lit = w_sel_en && !w_sel_blank;
    w_seg = w_lit ? f_decode(w_nib) : 7'h00;
    w_dp  = w_lit && w_sel_dp;
    if (!w_lit) begin
      w_an = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_idx        <= '0;
      r_tick       <= 1'b0;
      r_shadow_val <= '0;
      r_shadow_dp  <= '0;
      r_seg        <= {7{c_pol}};
      r_dp         <= c_pol;
      r_an         <= {NUM_DIGITS{c_pol}};
    end else begin
      r_cnt  <= w_tc ? '0 : r_cnt + 1'b1;
      r_tick <= w_tc;
      if (w_tc) begin
        r_idx <= (r_idx == c_idx_max) ? '0 : r_idx + 1'b1;
      end
      if (load) begin
        r_shadow_val <= value;
        r_shadow_dp  <= dp_in;
      end
      // Outputs come straight from flops so the digit hand-over is clean
      r_seg <= w_seg ^ {7{c_pol}};
      r_dp  <= w_dp ^ c_pol;
      r_an  <= w_an ^ {NUM_DIGITS{c_pol}};
    end
  end

  assign seg       = r_seg;
  assign dp        = r_dp;
  assign an        = r_an;
  assign scan_tick = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan_driver
// Purpose  : Scoreboard bench for seg7_scan_driver (4 digits, 4 clocks per
//            slot, active-low pins). A reference model derives each cycle's
//            expected pins from the clock count since reset and the shadow
//            contents; a monitor compares them on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

  localparam int ND  = 4;
  localparam int DIV = 4;

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       tick;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic [3:0]  digit_en = 4'hF;
  logic        blank_lz = 1'b0;
  logic        load = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        scan_tick;

  int checks = 0;
  int errors = 0;

  exp_t q[$];

  logic [6:0] seg_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                              7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  // Reference model state
  int   k;
  int   sh_nib [ND];
  int   sh_dp  [ND];
  int   m_d;
  bit   m_blank;
  bit   m_lit;
  exp_t m_e;

  seg7_scan_driver #(
    .NUM_DIGITS (ND),
    .REFRESH_DIV(DIV),
    .ACTIVE_LOW (1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .value    (value),
    .dp_in    (dp_in),
    .digit_en (digit_en),
    .blank_lz (blank_lz),
    .load     (load),
    .seg      (seg),
    .dp       (dp),
    .an       (an),
    .scan_tick(scan_tick)
  );

  always #5 clk = ~clk;

  // Reference model: after the k-th edge since reset the scanned slot is
  // (k/DIV) mod ND, and the pins show the slot of the previous cycle.
  initial begin
    k = 0;
    for (int j = 0; j < ND; j++) begin
      sh_nib[j] = 0;
      sh_dp[j]  = 0;
    end
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        k = 0;
        for (int j = 0; j < ND; j++) begin
          sh_nib[j] = 0;
          sh_dp[j]  = 0;
        end
        if (clk) begin
          m_e = '{seg: 7'h7F, dp: 1'b1, an: 4'hF, tick: 1'b0};
          q.push_back(m_e);
        end
      end else begin
        m_d     = (k / DIV) % ND;
        m_blank = 1'b0;
        if (blank_lz && m_d > 0) begin
          m_blank = 1'b1;
          for (int j = m_d; j < ND; j++) begin
            if (sh_nib[j] != 0) m_blank = 1'b0;
          end
        end
        m_lit    = digit_en[m_d] && !m_blank;
        m_e.seg  = m_lit ? seg_tab[sh_nib[m_d]] : 7'h00;
        m_e.dp   = m_lit && (sh_dp[m_d] != 0);
        m_e.an   = m_lit ? 4'(1 << m_d) : 4'h0;
        k        = k + 1;
        m_e.tick = ((k % DIV) == 0);
        m_e.seg  = ~m_e.seg;
        m_e.dp   = ~m_e.dp;
        m_e.an   = ~m_e.an;
        if (load) begin
          for (int j = 0; j < ND; j++) begin
            sh_nib[j] = int'(value[4*j +: 4]);
            sh_dp[j]  = int'(dp_in[j]);
          end
        end
        q.push_back(m_e);
      end
    end
  end

  // Monitor: compare every registered output update on the falling edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if ({seg, dp, an, scan_tick} !== e) begin
          errors++;
          $display("FAIL scoreboard t=%0t got seg=%h dp=%b an=%h tick=%b required seg=%h dp=%b an=%h tick=%b",
                   $time, seg, dp, an, scan_tick, e.seg, e.dp, e.an, e.tick);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value = v;
    dp_in = d;
    load  = 1'b1;
    step(1);
    load  = 1'b0;
  endtask

  initial begin
    step(3);
    rst_n = 1'b1;

    // Basic scan of 1234
    do_load(16'h1234, 4'h0);
    step(20);

    // Every nibble value on digit 0
    for (int v = 0; v < 16; v++) begin
      do_load({12'h123, 4'(v)}, 4'h0);
      step(16);
    end

    // Leading-zero suppression
    blank_lz = 1'b1;
    do_load(16'h0050, 4'h0);
    step(16);
    do_load(16'h0000, 4'h0);
    step(16);
    blank_lz = 1'b0;

    // Value changes without load must not reach the display
    do_load(16'hABCD, 4'h0);
    value = 16'h5555;
    step(16);

    // Load in the same cycle as the tick
    for (int i = 0; i < 2*DIV && !scan_tick; i++) step(1);
    checks++;
    if (!scan_tick) begin
      errors++;
      $display("FAIL tick_wait got scan_tick=%b required 1 within %0d cycles", scan_tick, 2*DIV);
    end
    do_load(16'h9876, 4'h0);
    step(16);

    // Disabled digits and decimal point
    digit_en = 4'b0101;
    do_load(16'h4321, 4'b0100);
    step(16);
    digit_en = 4'hF;

    // Randomized traffic
    repeat (400) begin
      value    = 16'($urandom);
      dp_in    = 4'($urandom);
      digit_en = 4'($urandom);
      blank_lz = 1'($urandom);
      load     = ($urandom_range(0, 3) == 0);
      step(1);
    end
    load     = 1'b0;
    digit_en = 4'hF;
    do_load(16'h8421, 4'b1010);
    step(6);

    // Asynchronous reset pulse between clock edges
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({an, seg, dp, scan_tick} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL async_reset got an=%h seg=%h dp=%b tick=%b required an=f seg=7f dp=1 tick=0",
               an, seg, dp, scan_tick);
    end
    #1 rst_n = 1'b1;
    step(20);
    do_load(16'h0F0F, 4'h1);
    step(20);

    step(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
